// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings (also used by
// ctrl decode), FSM state type and small op-class helpers.
package md_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdState_t;

  function automatic logic isMdArith(input logic [2:0] op);
    logic res;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic isMdDiv(input logic [2:0] op);
    logic res;
    case (op)
      MD_DIV, MD_DIVU: res = 1'b1;
      default:         res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath. All sign, divide-by-zero and
// overflow rules live here; resValid=0 means HI/LO must be left untouched.
module md_arith
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] resHi,
  output logic [WIDTH-1:0] resLo,
  output logic             resValid
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [2*WIDTH-1:0] prodU_s;
  logic [2*WIDTH-1:0] prodS_s;
  logic               bZero_s;
  logic [WIDTH-1:0]   bSafe_s;
  logic [WIDTH-1:0]   aMag_s;
  logic [WIDTH-1:0]   bMag_s;
  logic [WIDTH-1:0]   bMagSafe_s;
  logic [WIDTH-1:0]   qU_s;
  logic [WIDTH-1:0]   rU_s;
  logic [WIDTH-1:0]   qMag_s;
  logic [WIDTH-1:0]   rMag_s;
  logic [WIDTH-1:0]   qS_s;
  logic [WIDTH-1:0]   rS_s;

  // Sign-extending to 2*WIDTH makes the low 2*WIDTH bits of an unsigned product the signed product.
  assign prodU_s = {ZERO, a} * {ZERO, b};
  assign prodS_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};

  assign bZero_s    = (b == ZERO);
  assign bSafe_s    = bZero_s ? ONE : b;
  assign aMag_s     = a[WIDTH-1] ? (ZERO - a) : a;
  assign bMag_s     = b[WIDTH-1] ? (ZERO - b) : b;
  assign bMagSafe_s = bZero_s ? ONE : bMag_s;

  assign qU_s   = a / bSafe_s;
  assign rU_s   = a % bSafe_s;
  assign qMag_s = aMag_s / bMagSafe_s;
  assign rMag_s = aMag_s % bMagSafe_s;

  // Magnitude divide truncates toward zero; MIN / -1 wraps back to MIN with remainder 0.
  assign qS_s = (a[WIDTH-1] ^ b[WIDTH-1]) ? (ZERO - qMag_s) : qMag_s;
  assign rS_s = a[WIDTH-1] ? (ZERO - rMag_s) : rMag_s;

  // Result select by operation
  always_comb begin
    resHi    = ZERO;
    resLo    = ZERO;
    resValid = 1'b0;
    case (op)
      MD_MULT: begin
        resHi    = prodS_s[2*WIDTH-1:WIDTH];
        resLo    = prodS_s[WIDTH-1:0];
        resValid = 1'b1;
      end
      MD_MULTU: begin
        resHi    = prodU_s[2*WIDTH-1:WIDTH];
        resLo    = prodU_s[WIDTH-1:0];
        resValid = 1'b1;
      end
      MD_DIV: begin
        resHi    = rS_s;
        resLo    = qS_s;
        resValid = ~bZero_s;
      end
      MD_DIVU: begin
        resHi    = rU_s;
        resLo    = qU_s;
        resValid = ~bZero_s;
      end
      default: begin
        resHi    = ZERO;
        resLo    = ZERO;
        resValid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO. Results are
// computed at issue, parked in shadow registers, and committed when busy ends.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

  mdState_t         state_r,       nextState_s;
  logic [CNT_W-1:0] cnt_r,         nextCnt_s;
  logic             busy_r,        nextBusy_s;
  logic [WIDTH-1:0] hi_r,          nextHi_s;
  logic [WIDTH-1:0] lo_r,          nextLo_s;
  logic [WIDTH-1:0] shadowHi_r,    nextShadowHi_s;
  logic [WIDTH-1:0] shadowLo_r,    nextShadowLo_s;
  logic             shadowValid_r, nextShadowValid_s;

  logic [WIDTH-1:0] resHi_s;
  logic [WIDTH-1:0] resLo_s;
  logic             resValid_s;

  md_arith #(
    .WIDTH(WIDTH)
  ) uArith (
    .op      (op),
    .a       (a),
    .b       (b),
    .resHi   (resHi_s),
    .resLo   (resLo_s),
    .resValid(resValid_s)
  );

  // State, counter, HI/LO and shadow registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= CNT_ZERO;
      busy_r        <= 1'b0;
      hi_r          <= {WIDTH{1'b0}};
      lo_r          <= {WIDTH{1'b0}};
      shadowHi_r    <= {WIDTH{1'b0}};
      shadowLo_r    <= {WIDTH{1'b0}};
      shadowValid_r <= 1'b0;
    end else begin
      state_r       <= nextState_s;
      cnt_r         <= nextCnt_s;
      busy_r        <= nextBusy_s;
      hi_r          <= nextHi_s;
      lo_r          <= nextLo_s;
      shadowHi_r    <= nextShadowHi_s;
      shadowLo_r    <= nextShadowLo_s;
      shadowValid_r <= nextShadowValid_s;
    end
  end

  // Next-state, issue capture and commit logic
  always_comb begin
    nextState_s       = state_r;
    nextCnt_s         = cnt_r;
    nextBusy_s        = busy_r;
    nextHi_s          = hi_r;
    nextLo_s          = lo_r;
    nextShadowHi_s    = shadowHi_r;
    nextShadowLo_s    = shadowLo_r;
    nextShadowValid_s = shadowValid_r;
    case (state_r)
      ST_IDLE: begin
        nextBusy_s = 1'b0;
        if (start && isMdArith(op)) begin
          nextState_s       = ST_BUSY;
          nextCnt_s         = isMdDiv(op) ? CNT_DIV : CNT_MULT;
          nextBusy_s        = 1'b1;
          nextShadowHi_s    = resHi_s;
          nextShadowLo_s    = resLo_s;
          nextShadowValid_s = resValid_s;
        end else if (start && (op == MD_MTHI)) begin
          nextHi_s = a;
        end else if (start && (op == MD_MTLO)) begin
          nextLo_s = a;
        end else begin
          nextState_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // start is deliberately not looked at here: a second issue while busy is dropped
        if (cnt_r == CNT_ONE) begin
          nextState_s = ST_IDLE;
          nextCnt_s   = CNT_ZERO;
          nextBusy_s  = 1'b0;
          if (shadowValid_r) begin
            nextHi_s = shadowHi_r;
            nextLo_s = shadowLo_r;
          end else begin
            nextHi_s = hi_r;
            nextLo_s = lo_r;
          end
        end else begin
          nextCnt_s  = cnt_r - CNT_ONE;
          nextBusy_s = 1'b1;
        end
      end
      default: begin
        nextState_s = ST_IDLE;
        nextCnt_s   = CNT_ZERO;
        nextBusy_s  = 1'b0;
      end
    endcase
  end

  assign busy = busy_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule
